// File: rtl/csr_file.sv
// csr_file: RV32 machine-mode CSR file with 64-bit counters, trap entry, mret and interrupt-pending logic
module csr_file #(
    parameter int          XLEN        = 32,
    parameter logic [25:0] MISA_EXT    = 26'h0000100,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          COUNTERS_EN = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [11:0]     i_addr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_wd,
    input  logic            i_src_zero,
    output logic [XLEN-1:0] o_rd,
    output logic            o_illegal,
    input  logic            i_retire,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_val,
    input  logic            i_mret,
    input  logic [2:0]      i_irq,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_epc,
    output logic            o_irq_pending
);
    localparam logic [31:0] MISA = {2'b01, 4'b0, MISA_EXT};
    localparam bit CEN = COUNTERS_EN != 0;
    logic        status_mie, status_mpie;
    logic [2:0]  mie_r;
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0] cycle, instret, cyc_inc, ins_inc, cyc_n, ins_n;
    logic [1:0]  op;
    logic        attempt, mapped, we;
    logic [31:0] old, wv;
    assign op      = i_funct3[1:0];
    assign attempt = (op != 2'b00) & ~(op[1] & i_src_zero);
    always_comb begin
        mapped = 1'b1;
        old    = '0;
        case (i_addr)
            12'h300: old = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
            12'h301: old = MISA;
            12'h304: old = {20'b0, mie_r[2], 3'b0, mie_r[1], 3'b0, mie_r[0], 3'b0};
            12'h305: old = mtvec;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h343: old = mtval;
            12'h344: old = {20'b0, i_irq[2], 3'b0, i_irq[1], 3'b0, i_irq[0], 3'b0};
            12'hB00: old = cycle[31:0];
            12'hB80: old = cycle[63:32];
            12'hB02: old = instret[31:0];
            12'hB82: old = instret[63:32];
            12'hF14: old = HART_ID;
            default: mapped = 1'b0;
        endcase
    end
    assign o_illegal = i_en & (~mapped | (attempt & (&i_addr[11:10])));
    assign o_rd      = i_en ? old : '0;
    assign we        = i_en & attempt & ~o_illegal & ~i_trap;
    assign wv        = op == 2'b01 ? i_wd : op == 2'b10 ? old | i_wd : old & ~i_wd;
    // The written half wins; writing hi keeps lo counting but blocks its carry.
    assign cyc_inc = cycle + 64'd1;
    assign ins_inc = instret + {63'b0, i_retire};
    always_comb begin
        cyc_n[31:0]  = we && i_addr == 12'hB00 ? wv : cyc_inc[31:0];
        cyc_n[63:32] = we && i_addr == 12'hB80 ? wv : we && i_addr == 12'hB00 ? cycle[63:32] : cyc_inc[63:32];
        ins_n[31:0]  = we && i_addr == 12'hB02 ? wv : ins_inc[31:0];
        ins_n[63:32] = we && i_addr == 12'hB82 ? wv : we && i_addr == 12'hB02 ? instret[63:32] : ins_inc[63:32];
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_r       <= '0;
            mtvec       <= MTVEC_RESET & ~32'h2;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            cycle       <= '0;
            instret     <= '0;
        end else begin
            cycle   <= CEN ? cyc_n : '0;
            instret <= CEN ? ins_n : '0;
            if (i_trap) begin
                mepc        <= i_trap_pc & ~32'h3;
                mcause      <= i_trap_cause;
                mtval       <= i_trap_val;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else begin
                if (we && i_addr == 12'h300) begin
                    status_mie  <= wv[3];
                    status_mpie <= wv[7];
                end
                if (we && i_addr == 12'h304) mie_r <= {wv[11], wv[7], wv[3]};
                if (we && i_addr == 12'h305) mtvec <= wv & ~32'h2;
                if (we && i_addr == 12'h340) mscratch <= wv;
                if (we && i_addr == 12'h341) mepc <= wv & ~32'h3;
                if (we && i_addr == 12'h342) mcause <= wv;
                if (we && i_addr == 12'h343) mtval <= wv;
                // mret sees the MPIE a same-cycle mstatus write just produced
                if (i_mret) begin
                    status_mie  <= we && i_addr == 12'h300 ? wv[7] : status_mpie;
                    status_mpie <= 1'b1;
                end
            end
        end
    end
    assign o_trap_vector = {mtvec[31:2], 2'b00} + (mtvec[0] & i_trap_cause[31] ? {25'b0, i_trap_cause[4:0], 2'b00} : 32'd0);
    assign o_epc         = mepc;
    assign o_irq_pending = status_mie & |(i_irq & mie_r);
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus random stimulus checked against an abstract CSR model
module tb_csr_file;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, en, sz, retire, trap, mret;
    logic [11:0] addr;
    logic [2:0]  f3, irq;
    logic [31:0] wd, cause, pc, tval;
    logic [31:0] o_rd, o_trap_vector, o_epc;
    logic        o_illegal, o_irq_pending;
    csr_file dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_addr(addr), .i_funct3(f3), .i_wd(wd),
        .i_src_zero(sz), .o_rd(o_rd), .o_illegal(o_illegal), .i_retire(retire),
        .i_trap(trap), .i_trap_cause(cause), .i_trap_pc(pc), .i_trap_val(tval),
        .i_mret(mret), .i_irq(irq), .o_trap_vector(o_trap_vector), .o_epc(o_epc),
        .o_irq_pending(o_irq_pending)
    );
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // reference model state
    bit          m_sie, m_spie;
    logic [31:0] m_mie, m_mtvec, m_scr, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc, m_ins;
    task automatic m_reset();
        m_sie = 0; m_spie = 0; m_mie = 0; m_mtvec = 0; m_scr = 0;
        m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ins = 0;
    endtask
    function automatic logic [31:0] m_mip();
        return (32'(irq[2]) << 11) | (32'(irq[1]) << 7) | (32'(irq[0]) << 3);
    endfunction
    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction
    function automatic logic [31:0] m_val(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_sie) << 3) | (32'(m_spie) << 7);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_mip();
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction
    task automatic tick();
        logic [1:0]  op;
        logic [31:0] old, nv, tv;
        bit          att, ill, we;
        #1;
        op  = f3[1:0];
        old = m_val(addr);
        att = op != 0 && !(op[1] && sz);
        ill = en && (!m_mapped(addr) || (att && addr[11:10] == 2'b11));
        we  = en && att && !ill && !trap;
        nv  = op == 2'b01 ? wd : op == 2'b10 ? (old | wd) : (old & ~wd);
        tv  = (m_mtvec & ~32'h3) + ((m_mtvec[0] && cause[31]) ? 32'(cause[4:0]) * 4 : 32'd0);
        chk("rd", o_rd, (en && m_mapped(addr)) ? old : 32'd0);
        chk("illegal", 32'(o_illegal), 32'(ill));
        chk("trap_vector", o_trap_vector, tv);
        chk("epc", o_epc, m_epc);
        chk("irq_pending", 32'(o_irq_pending), 32'(m_sie && (m_mip() & m_mie) != 0));
        @(posedge clk);
        if (rst) m_reset();
        else begin
            if (we && addr == 12'hB00) m_cyc[31:0] = nv;
            else if (we && addr == 12'hB80) begin m_cyc[31:0] = m_cyc[31:0] + 1; m_cyc[63:32] = nv; end
            else m_cyc = m_cyc + 1;
            if (we && addr == 12'hB02) m_ins[31:0] = nv;
            else if (we && addr == 12'hB82) begin m_ins[31:0] = m_ins[31:0] + 32'(retire); m_ins[63:32] = nv; end
            else m_ins = m_ins + 64'(retire);
            if (trap) begin
                m_epc = pc & ~32'h3; m_cause = cause; m_tval = tval;
                m_spie = m_sie; m_sie = 0;
            end else begin
                if (we)
                    case (addr)
                        12'h300: begin m_sie = nv[3]; m_spie = nv[7]; end
                        12'h304: m_mie = nv & 32'h888;
                        12'h305: m_mtvec = nv & ~32'h2;
                        12'h340: m_scr = nv;
                        12'h341: m_epc = nv & ~32'h3;
                        12'h342: m_cause = nv;
                        12'h343: m_tval = nv;
                        default: ;
                    endcase
                if (mret) begin m_sie = m_spie; m_spie = 1; end
            end
        end
        @(negedge clk);
    endtask
    task automatic idle();
        en = 0; addr = 0; f3 = 0; wd = 0; sz = 0; retire = 0;
        trap = 0; mret = 0; rst = 0; cause = 0; pc = 0; tval = 0;
    endtask
    task automatic csr(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d, input logic z);
        en = 1; addr = a; f3 = f; wd = d; sz = z;
    endtask
    task automatic rdc(input logic [11:0] a);
        csr(a, 3'b010, 32'd0, 1'b1);
    endtask
    task automatic expect_rd(input string tag, input logic [31:0] e);
        #1;
        chk(tag, o_rd, e);
    endtask
    logic [11:0] addrs[18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                               12'h7C0, 12'h306, 12'hF11, 12'hC00};
    initial begin
        logic [31:0] c;
        idle(); irq = 0; rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        tick(); rst = 0;
        rdc(12'h301); expect_rd("misa", 32'h4000_0100); chk("misa_rs_zero_legal", 32'(o_illegal), 0); tick();
        rdc(12'hF14); expect_rd("mhartid", 0); tick();
        rdc(12'h7C0); #1 chk("unmapped_illegal", 32'(o_illegal), 1); chk("unmapped_rd", o_rd, 0); tick();
        csr(12'h340, 3'b001, 32'hA5A5_0000, 0); expect_rd("mscratch_rw", 0); tick();
        csr(12'h340, 3'b010, 32'h0000_00FF, 0); expect_rd("mscratch_rs", 32'hA5A5_0000); tick();
        csr(12'h340, 3'b011, 32'hA500_0000, 0); expect_rd("mscratch_rc", 32'hA5A5_00FF); tick();
        rdc(12'h340); expect_rd("mscratch_final", 32'h00A5_00FF); tick();
        csr(12'hB00, 3'b001, 32'hFFFF_FFFE, 0); tick();
        csr(12'hB80, 3'b001, 32'd0, 0); tick();
        idle(); tick();
        rdc(12'hB00); expect_rd("mcycle_wrap", 0); tick();
        rdc(12'hB80); expect_rd("mcycleh_carry", 1); tick();
        csr(12'hB00, 3'b001, 32'd5, 0); tick();
        rdc(12'hB00); expect_rd("mcycle_write_wins", 5); tick();
        idle(); tick();
        rdc(12'hB00); expect_rd("mcycle_after", 7); tick();
        csr(12'h300, 3'b001, 32'h8, 0); tick();
        csr(12'h304, 3'b001, 32'h80, 0); tick();
        csr(12'h305, 3'b001, 32'h1001, 0); tick();
        idle(); irq = 3'b010; #1 chk("irq_pending_set", 32'(o_irq_pending), 1); tick();
        trap = 1; cause = 32'h8000_0007; pc = 32'h1236; tval = 32'h55;
        #1 chk("vectored", o_trap_vector, 32'h0000_101C); tick();
        idle(); rdc(12'h341); expect_rd("mepc_trap", 32'h1234);
        chk("epc_trap", o_epc, 32'h1234); chk("irq_masked", 32'(o_irq_pending), 0); tick();
        rdc(12'h300); expect_rd("mstatus_trap", 32'h1880); tick();
        idle(); mret = 1; tick();
        idle(); rdc(12'h300); expect_rd("mstatus_mret", 32'h1888); chk("epc_mret", o_epc, 32'h1234); tick();
        csr(12'h340, 3'b001, 32'hDEAD_BEEF, 0); trap = 1; cause = 32'd2; pc = 32'h4000; mret = 1; tick();
        idle(); rdc(12'h340); expect_rd("mscratch_kept", 32'h00A5_00FF); tick();
        rdc(12'h300); expect_rd("mstatus_trap_wins", 32'h1880); tick();
        rdc(12'h341); expect_rd("mepc_trap_wins", 32'h4000); tick();
        csr(12'h305, 3'b001, 32'hFFFF_FFFF, 0); tick();
        rdc(12'h305); expect_rd("mtvec_bit1", 32'hFFFF_FFFD); tick();
        csr(12'h340, 3'b001, 32'h1, 0); rst = 1; tick();
        idle(); rdc(12'hB00); expect_rd("mcycle_reset", 0); tick();
        rdc(12'h340); expect_rd("mscratch_reset", 0); tick();
        rdc(12'h305); expect_rd("mtvec_reset", 0); tick();
        for (int i = 0; i < 3000; i++) begin
            idle();
            en = $urandom_range(0, 3) != 0;
            addr = addrs[$urandom_range(0, 17)];
            f3 = 3'($urandom);
            sz = $urandom_range(0, 3) == 0;
            wd = sz ? 32'd0 : ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
            retire = 1'($urandom);
            trap = $urandom_range(0, 19) == 0;
            c = $urandom;
            cause = $urandom_range(0, 1) ? {c[31], 26'b0, c[4:0]} : c;
            pc = $urandom; tval = $urandom;
            mret = $urandom_range(0, 14) == 0;
            irq = 3'($urandom);
            rst = $urandom_range(0, 299) == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR file for the single-hart core. Adds writable state, CSR read-modify-write ops, 64-bit cycle and instret counters, trap entry, mret and interrupt-pending generation. Read-only identification registers are also provided. Sits beside the execute stage: the decoder supplies the address, op and operand, and the trap unit drives trap and mret.

Parameters:
XLEN, 32, data width; 32 only (RV32), counters split lo/hi.
MISA_EXT, 26'h0000100, misa extension bits [25:0]; MXL fixed to 2'b01.
HART_ID, 0, value returned by mhartid.
MTVEC_RESET, 32'h0000_0000, mtvec reset value.
COUNTERS_EN, 1, 0 removes mcycle/minstret (reads 0, writes ignored, no o_illegal).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  CSR instruction valid this cycle
i_addr  in  12  CSR address
i_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; others are a no-op
i_wd  in  XLEN  operand: rs1 value or zero-extended uimm, already selected by the decoder
i_src_zero  in  1  rs1 index or uimm is zero
o_rd  out  XLEN  old CSR value (combinational)
o_illegal  out  1  illegal access (combinational)
i_retire  in  1  one instruction retired this cycle
i_trap  in  1  take trap this cycle
i_trap_cause  in  XLEN  mcause value; bit 31 = interrupt
i_trap_pc  in  XLEN  faulting/interrupted PC
i_trap_val  in  XLEN  mtval value
i_mret  in  1  mret executing
i_irq  in  3  {MEIP, MTIP, MSIP} level inputs
o_trap_vector  out  XLEN  trap target PC
o_epc  out  XLEN  mepc, for mret
o_irq_pending  out  1  interrupt should be taken

Behaviour:
- Registers and addresses:
  - misa 0x301 RO: {2'b01, 4'b0, MISA_EXT}.
  - mhartid 0xF14 RO.
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: bits 11, 7, 3 writable.
  - mip 0x344 RO: bits 11/7/3 = i_irq[2]/[1]/[0].
  - mtvec 0x305: bit 1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342; mtval 0x343.
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
- Read: o_rd shows the pre-write value in the same cycle. o_rd = 0 when i_en = 0 or the address is unmapped.
- Write value:
  - RW/RWI: wd.
  - RS/RSI: old | wd.
  - RC/RCI: old & ~wd.
- Write enable = i_en & valid funct3 & !illegal & !(RS/RC-type & i_src_zero) & !i_trap. The write lands at the next rising edge.
- o_illegal = i_en & (unmapped address | (write attempted & addr[11:10] == 2'b11)). RS/RC with i_src_zero on a RO register is legal. Illegal accesses change no state.
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments by 1 when i_retire = 1.
  - Both are 64-bit and wrap from all-ones to 0.
  - A CSR write to either half in the same cycle wins: that half takes the written value and the counter is not incremented that cycle. A carry from lo into hi is suppressed when hi is the half being written.
- Trap (i_trap = 1, highest priority):
  - mepc <= {i_trap_pc[31:2], 2'b00}; mcause <= i_trap_cause; mtval <= i_trap_val.
  - MPIE <= MIE; MIE <= 0.
  - Any concurrent CSR write is dropped.
  - i_mret is ignored when i_trap = 1.
- o_trap_vector (combinational):
  - {mtvec[31:2], 2'b00}.
  - If mtvec[0] = 1 and i_trap_cause[31] = 1, add 4 × cause[4:0].
- mret (i_mret = 1, no trap):
  - MIE <= MPIE; MPIE <= 1.
  - A concurrent CSR write to mstatus is applied first, then the mret update overrides MIE/MPIE.
- o_epc = mepc (registered value).
- o_irq_pending = MIE & |(mip & mie), combinational from i_irq.
- Reset values:
  - mstatus MIE = MPIE = 0.
  - mie, mscratch, mepc, mcause, mtval = 0.
  - mtvec = MTVEC_RESET.
  - Counters = 0.
  - The first increment happens on the first edge after reset deasserts.
- Reset asserted mid-operation overrides trap, mret and write in that cycle.

Test Plan:
- Reset, then read misa with default MISA_EXT -> o_rd = 32'h4000_0100. Read mhartid -> 0. Read 0x7C0 -> o_illegal = 1, o_rd = 0.
- RW mscratch 0xA5A5_0000, then RS with 0x0000_00FF, then RC with 0xA500_0000 -> reads return 0, then 0xA5A5_0000, then 0xA5A5_00FF; final value 0x00A5_00FF. RS with i_src_zero on misa -> no illegal, no change.
- Write mcycle = 0xFFFF_FFFE, mcycleh = 0 -> two cycles later mcycle = 0, mcycleh = 1. Write mcycle = 5 while counting -> next read is 5 + elapsed cycles, with no +1 in the write cycle.
- MIE = 1, mie[7] = 1, i_irq = 3'b010 -> o_irq_pending = 1. Trap with cause 0x8000_0007 and pc 0x1236, mtvec = 0x0000_1001 -> o_trap_vector = 0x0000_101C; next cycle mepc = 0x1234, MIE = 0, MPIE = 1, o_irq_pending = 0.
- i_mret after the trap -> MIE = 1, MPIE = 1, o_epc = 0x1234. Trap and mret plus a CSR write to mscratch all in the same cycle -> trap state is taken, mscratch unchanged.
- Write mtvec = 0xFFFF_FFFF -> reads 0xFFFF_FFFD. Assert i_rst mid-counting -> all registers return to reset values on the next edge.
